// File: rtl/reg_fifo_sc.sv
`default_nettype none
// ============================================================================
//  Module   : reg_fifo_sc
//  Brief    : Single-clock register FIFO with valid/ready on both sides,
//             first-word-fall-through output, occupancy/almost-full status,
//             synchronous flush and a saturating dropped-write counter.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_fifo_sc #(
    parameter int DWIDTH       = 32,
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = DEPTH - 3,
    parameter int CNT_WIDTH    = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [DWIDTH-1:0]    in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DWIDTH-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_WIDTH-1:0] occupancy,
    output logic                 almost_full,
    output logic [31:0]          overflow_cnt
);

    localparam int                   PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] C_DEPTH = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] C_AFULL = CNT_WIDTH'(AFULL_THRESH);
    localparam logic [PTR_W-1:0]     C_PTR_ONE = PTR_W'(1);
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = CNT_WIDTH'(1);

    logic [DWIDTH-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_WIDTH-1:0] r_count;
    logic [31:0]          r_overflow_cnt;

    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_drop;

    // Handshake decode; in_ready looks only at registered count so there is
    // no combinational path from out_ready through to in_ready.
    always_comb begin
        w_full   = (r_count == C_DEPTH);
        in_ready = !w_full && !rst;
        w_push   = in_valid && in_ready;
        w_pop    = out_valid && out_ready;
        w_drop   = in_valid && !in_ready && !rst && !flush;
    end

    // Status and fall-through head outputs, all straight from registered state.
    always_comb begin
        out_valid    = (r_count != '0);
        out_data     = r_mem[r_rd_ptr];
        occupancy    = r_count;
        almost_full  = (r_count >= C_AFULL);
        overflow_cnt = r_overflow_cnt;
    end

    // Storage array; not reset, a flushed cycle writes nothing.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    // Pointers and count; flush overrides any transfer in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + C_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - C_CNT_ONE;
            end
        end
    end

    // Dropped-write counter; survives flush, sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow_cnt <= '0;
        end else if (w_drop && (r_overflow_cnt != '1)) begin
            r_overflow_cnt <= r_overflow_cnt + 32'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_fifo_sc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_fifo_sc
//  Brief    : Directed plus short random bench for reg_fifo_sc using a
//             queue-based reference model of contents and counters.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_fifo_sc;

    localparam int DWIDTH       = 32;
    localparam int DEPTH        = 8;
    localparam int AFULL_THRESH = 5;
    localparam int CNT_WIDTH    = $clog2(DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 flush = 1'b0;
    logic [DWIDTH-1:0]    in_data = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [DWIDTH-1:0]    out_data;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [CNT_WIDTH-1:0] occupancy;
    logic                 almost_full;
    logic [31:0]          overflow_cnt;

    int          nvec  = 0;
    int          nfail = 0;
    logic [31:0] q [$];
    logic [31:0] m_ovf = 32'd0;

    reg_fifo_sc #(
        .DWIDTH      (DWIDTH),
        .DEPTH       (DEPTH),
        .AFULL_THRESH(AFULL_THRESH),
        .CNT_WIDTH   (CNT_WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .occupancy   (occupancy),
        .almost_full (almost_full),
        .overflow_cnt(overflow_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("occupancy",   32'(occupancy),   32'(q.size()));
        chk("out_valid",   32'(out_valid),   32'(q.size() != 0));
        chk("in_ready",    32'(in_ready),    32'(q.size() != DEPTH));
        chk("almost_full", 32'(almost_full), 32'(q.size() >= AFULL_THRESH));
        chk("overflow",    overflow_cnt,     m_ovf);
        if (q.size() != 0) begin
            chk("head", out_data, q[0]);
        end
    endtask

    // One clock of stimulus; model updated from its own view of the FIFO.
    task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
        logic push;
        logic pop;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        pop  = (q.size() != 0) && ordy;
        push = iv && (q.size() != DEPTH);
        if (pop) begin
            chk("pop_data", out_data, q[0]);
        end
        if (fl) begin
            q.delete();
        end else begin
            if (iv && !push && (m_ovf != 32'hFFFF_FFFF)) begin
                m_ovf = m_ovf + 32'd1;
            end
            if (pop) begin
                void'(q.pop_front());
            end
            if (push) begin
                q.push_back(d);
            end
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    // Hold reset with in_valid asserted (must not count as drops), then release.
    task automatic do_reset(input int cycles);
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        flush     = 1'b0;
        q.delete();
        m_ovf = 32'd0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            chk("rst_in_ready", 32'(in_ready),    32'd0);
            chk("rst_occ",      32'(occupancy),   32'd0);
            chk("rst_valid",    32'(out_valid),   32'd0);
            chk("rst_afull",    32'(almost_full), 32'd0);
            chk("rst_ovf",      overflow_cnt,     32'd0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        step(1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        // Power-on reset
        do_reset(2);

        // Fill 1..8 with consumer stalled
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 32'(i), 1'b0, 1'b0);
        end
        // Writes offered while full: three drops
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'hDEAD_0000 + 32'(i), 1'b0, 1'b0);
        end
        chk("ovf_three", overflow_cnt, 32'd3);
        // Full with push and pop together: only the pop happens
        step(1'b1, 32'hBEEF, 1'b1, 1'b0);
        chk("full_pp_occ", 32'(occupancy), 32'd7);
        chk("full_pp_ovf", overflow_cnt,   32'd4);
        // in_ready back one cycle after the first pop
        chk("full_pp_rdy", 32'(in_ready),  32'd1);
        // Drain the rest
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'd0, 1'b1, 1'b0);
        end

        // Push into empty FIFO with consumer ready: visible the next cycle
        in_valid = 1'b1;
        in_data = 32'hA5;
        out_ready = 1'b1;
        #1;
        chk("empty_same_cycle", 32'(out_valid), 32'd0);
        step(1'b1, 32'hA5, 1'b1, 1'b0);
        chk("empty_next", out_data, 32'hA5);
        step(1'b0, 32'd0, 1'b1, 1'b0);

        // Stream at count 4 across pointer wrap
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
        end
        for (int i = 4; i < 24; i++) begin
            step(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0);
        end
        chk("stream_occ", 32'(occupancy), 32'd4);

        // Flush at count 5 together with push and pop
        step(1'b1, 32'h200, 1'b0, 1'b0);
        step(1'b1, 32'h201, 1'b1, 1'b1);
        chk("flush_occ",   32'(occupancy), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ovf",   overflow_cnt,   32'd4);

        // Reach count 6 then reset mid-stream
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
        end
        do_reset(2);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 31) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
